// File: rtl/aes_block_scheduler.sv
// AES block scheduler: moves one packet at a time from the input FIFO through
// the AES core to the output FIFO, handling key loads and CBC chaining.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a packet; latches the command on first data
// KEY      | popping the key block
// KWAIT    | key expansion in progress
// IV       | popping the CBC initialisation vector
// POP      | popping the next payload block
// START    | aes_start high for one cycle
// WAIT     | waiting for the core result
// PUSH     | offering the result to the output FIFO
// DRAIN    | between blocks; ends the packet or pops again
module aes_block_scheduler #(
  parameter int WORD_S  = 32,
  parameter int BLK_S   = 128,
  parameter int CMD_ENC = 0,
  parameter int CMD_DEC = 1,
  parameter int CMD_KEY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WORD_S-1:0] axis_cmd,
  input  logic              axis_slave_done,
  input  logic [BLK_S-1:0]  in_fifo_rdata,
  input  logic              in_fifo_read_tvalid,
  input  logic              in_fifo_empty,
  output logic              in_fifo_r_e,
  output logic [BLK_S-1:0]  aes_key,
  output logic              aes_key_load,
  input  logic              aes_key_done,
  output logic [BLK_S-1:0]  aes_blk_in,
  output logic              aes_decrypt,
  output logic              aes_start,
  input  logic              aes_done,
  input  logic [BLK_S-1:0]  aes_blk_out,
  output logic [BLK_S-1:0]  out_fifo_wdata,
  output logic              out_fifo_wvalid,
  input  logic              out_fifo_wready,
  output logic              sched_busy,
  output logic              sched_done
);

  localparam logic [1:0] OP_ENC = 2'(CMD_ENC);
  localparam logic [1:0] OP_DEC = 2'(CMD_DEC);
  localparam logic [1:0] OP_KEY = 2'(CMD_KEY);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KEY,
    ST_KWAIT,
    ST_IV,
    ST_POP,
    ST_START,
    ST_WAIT,
    ST_PUSH,
    ST_DRAIN
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             cbc_q;
  logic [BLK_S-1:0] iv_q;
  logic [BLK_S-1:0] next_iv_q;

  logic [1:0] new_op;
  logic       new_cbc;
  logic       op_enc;
  logic       op_dec;
  logic       pop;
  logic       cmd_unused;

  // Only the low three command bits carry meaning.
  assign cmd_unused = ^axis_cmd[WORD_S-1:3];

  assign new_op  = axis_cmd[1:0];
  // Chaining is only meaningful for encrypt/decrypt packets.
  assign new_cbc = axis_cmd[2] && ((new_op == OP_ENC) || (new_op == OP_DEC));
  assign op_enc  = (op_q == OP_ENC);
  assign op_dec  = (op_q == OP_DEC);

  // The scheduler is always ready to take a block while in a popping state.
  assign in_fifo_r_e = (state == ST_POP) || (state == ST_KEY) || (state == ST_IV);
  assign pop         = in_fifo_r_e && in_fifo_read_tvalid;
  assign sched_busy  = (state != ST_IDLE);

  // Packet sequencing FSM with registered core/FIFO control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      op_q            <= 2'd0;
      cbc_q           <= 1'b0;
      iv_q            <= '0;
      next_iv_q       <= '0;
      aes_key         <= '0;
      aes_key_load    <= 1'b0;
      aes_blk_in      <= '0;
      aes_decrypt     <= 1'b0;
      aes_start       <= 1'b0;
      out_fifo_wdata  <= '0;
      out_fifo_wvalid <= 1'b0;
      sched_done      <= 1'b0;
    end else begin
      aes_key_load <= 1'b0;
      aes_start    <= 1'b0;
      sched_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!in_fifo_empty) begin
            op_q  <= new_op;
            cbc_q <= new_cbc;
            if (new_op == OP_KEY) state <= ST_KEY;
            else if (new_cbc)     state <= ST_IV;
            else                  state <= ST_POP;
          end
        end
        ST_KEY: begin
          if (pop) begin
            aes_key      <= in_fifo_rdata;
            aes_key_load <= 1'b1;
            state        <= ST_KWAIT;
          end
        end
        ST_KWAIT: begin
          if (aes_key_done) state <= ST_DRAIN;
        end
        ST_IV: begin
          if (pop) begin
            iv_q  <= in_fifo_rdata;
            state <= ST_POP;
          end
        end
        ST_POP: begin
          if (pop) begin
            if (op_enc || op_dec) begin
              aes_blk_in  <= (op_enc && cbc_q) ? (in_fifo_rdata ^ iv_q) : in_fifo_rdata;
              if (op_dec && cbc_q) next_iv_q <= in_fifo_rdata;
              aes_decrypt <= op_dec;
              aes_start   <= 1'b1;
              state       <= ST_START;
            end else begin
              // Set-key extras and reserved-op payload are discarded.
              state <= ST_DRAIN;
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (aes_done) begin
            out_fifo_wvalid <= 1'b1;
            if (cbc_q && op_enc) begin
              out_fifo_wdata <= aes_blk_out;
              iv_q           <= aes_blk_out;
            end else if (cbc_q && op_dec) begin
              out_fifo_wdata <= aes_blk_out ^ iv_q;
              iv_q           <= next_iv_q;
            end else begin
              out_fifo_wdata <= aes_blk_out;
            end
            state <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (out_fifo_wready) begin
            out_fifo_wvalid <= 1'b0;
            state           <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (axis_slave_done && in_fifo_empty) begin
            sched_done <= 1'b1;
            state      <= ST_IDLE;
          end else if (in_fifo_read_tvalid) begin
            state <= ST_POP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Bench for aes_block_scheduler: FIFO and core stand-ins plus a packet-level
// reference model of ECB/CBC behaviour.
module tb_aes_block_scheduler;

  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX = 128'ha5a5_5a5a_c3c3_3c3c_0f0f_f0f0_9696_6969;

  logic         clk = 1'b0;
  logic         resetn;
  logic [31:0]  axis_cmd;
  logic         axis_slave_done;
  logic [127:0] in_fifo_rdata;
  logic         in_fifo_read_tvalid;
  logic         in_fifo_empty;
  logic         in_fifo_r_e;
  logic [127:0] aes_key;
  logic         aes_key_load;
  logic         aes_key_done;
  logic [127:0] aes_blk_in;
  logic         aes_decrypt;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_blk_out;
  logic [127:0] out_fifo_wdata;
  logic         out_fifo_wvalid;
  logic         out_fifo_wready;
  logic         sched_busy;
  logic         sched_done;

  always #5 clk = ~clk;

  aes_block_scheduler dut (
    .clk                 (clk),
    .resetn              (resetn),
    .axis_cmd            (axis_cmd),
    .axis_slave_done     (axis_slave_done),
    .in_fifo_rdata       (in_fifo_rdata),
    .in_fifo_read_tvalid (in_fifo_read_tvalid),
    .in_fifo_empty       (in_fifo_empty),
    .in_fifo_r_e         (in_fifo_r_e),
    .aes_key             (aes_key),
    .aes_key_load        (aes_key_load),
    .aes_key_done        (aes_key_done),
    .aes_blk_in          (aes_blk_in),
    .aes_decrypt         (aes_decrypt),
    .aes_start           (aes_start),
    .aes_done            (aes_done),
    .aes_blk_out         (aes_blk_out),
    .out_fifo_wdata      (out_fifo_wdata),
    .out_fifo_wvalid     (out_fifo_wvalid),
    .out_fifo_wready     (out_fifo_wready),
    .sched_busy          (sched_busy),
    .sched_done          (sched_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Toy invertible cipher standing in for the core, with the FIPS-197 pair wired in.
  function automatic logic [127:0] core_enc(input logic [127:0] k, input logic [127:0] x);
    logic [127:0] t;
    if (k == FK && x == FP) return FC;
    t = x ^ k;
    return {t[120:0], t[127:121]} ^ MIX;
  endfunction

  function automatic logic [127:0] core_dec(input logic [127:0] k, input logic [127:0] y);
    logic [127:0] t;
    if (k == FK && y == FC) return FP;
    t = y ^ MIX;
    return {t[6:0], t[127:7]} ^ k;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input FIFO: array written by the stimulus, head advanced on each pop.
  logic [127:0] mem [0:255];
  int   head = 0;
  int   tail = 0;
  bit   gap_en = 1'b0;
  logic gap;
  int   pop_cnt = 0;
  int   last_pop_cyc = 0;

  assign in_fifo_empty       = (head == tail);
  assign in_fifo_read_tvalid = (head != tail) && !gap;
  assign in_fifo_rdata       = mem[head[7:0]];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= tail;
      gap  <= 1'b0;
    end else begin
      if (in_fifo_r_e && in_fifo_read_tvalid) begin
        head         <= head + 1;
        pop_cnt      <= pop_cnt + 1;
        last_pop_cyc <= cyc;
      end
      gap <= gap_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Core stand-in with programmable latency.
  int           core_lat = 2;
  int           key_lat  = 3;
  int           ccnt, kcnt;
  logic [127:0] core_key, core_res;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_key     <= '0;
      core_res     <= '0;
      ccnt         <= 0;
      kcnt         <= 0;
      aes_done     <= 1'b0;
      aes_key_done <= 1'b0;
      aes_blk_out  <= '0;
    end else begin
      aes_done     <= 1'b0;
      aes_key_done <= 1'b0;
      if (aes_key_load) begin
        core_key <= aes_key;
        kcnt     <= key_lat;
      end else if (kcnt == 1) begin
        aes_key_done <= 1'b1;
        kcnt         <= 0;
      end else if (kcnt > 0) begin
        kcnt <= kcnt - 1;
      end
      if (aes_start) begin
        if (core_lat == 1) begin
          aes_done    <= 1'b1;
          aes_blk_out <= aes_decrypt ? core_dec(core_key, aes_blk_in) : core_enc(core_key, aes_blk_in);
        end else begin
          core_res <= aes_decrypt ? core_dec(core_key, aes_blk_in) : core_enc(core_key, aes_blk_in);
          ccnt     <= core_lat - 1;
        end
      end else if (ccnt == 1) begin
        aes_done    <= 1'b1;
        aes_blk_out <= core_res;
        ccnt        <= 0;
      end else if (ccnt > 0) begin
        ccnt <= ccnt - 1;
      end
    end
  end

  // Output FIFO sink and event counters. wr_mode: 0 ready, 1 random, 2 blocked.
  int           wr_mode = 0;
  logic [127:0] outd [0:255];
  int           out_cnt = 0;
  int           done_cnt = 0;
  int           kl_cnt = 0;
  int           last_wr_cyc = 0;
  int           last_done_cyc = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_fifo_wready <= 1'b0;
    end else begin
      if (out_fifo_wvalid && out_fifo_wready) begin
        outd[out_cnt[7:0]] <= out_fifo_wdata;
        out_cnt            <= out_cnt + 1;
        last_wr_cyc        <= cyc;
      end
      if (sched_done) begin
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
      end
      if (aes_key_load) kl_cnt <= kl_cnt + 1;
      case (wr_mode)
        0:       out_fifo_wready <= 1'b1;
        1:       out_fifo_wready <= 1'($urandom_range(0, 1));
        default: out_fifo_wready <= 1'b0;
      endcase
    end
  end

  // A stalled write must stay offered with unchanged data.
  bit           stall_prev = 1'b0;
  logic [127:0] prev_wdata;
  always @(negedge clk) begin
    if (resetn && stall_prev) begin
      chk("wvalid_hold", 512'(out_fifo_wvalid), 512'(1));
      chk("wdata_hold", 512'(out_fifo_wdata), 512'(prev_wdata));
    end
    stall_prev = resetn && out_fifo_wvalid && !out_fifo_wready;
    prev_wdata = out_fifo_wdata;
  end

  // Packet-level reference model state.
  logic [127:0] pblk [0:7];
  logic [127:0] expq [0:7];
  int           exp_n;
  logic [127:0] m_key = '0;
  logic [127:0] m_iv  = '0;
  logic [1:0]   cur_op;
  bit           cur_cbc;
  int           base_wr, base_done, base_kl;

  task automatic push_blk(input logic [127:0] b);
    mem[tail[7:0]] = b;
    tail = tail + 1;
  endtask

  task automatic load_packet(input logic [1:0] op, input bit cbc, input int n, input logic [127:0] ivv);
    logic [127:0] c;
    base_wr   = out_cnt;
    base_done = done_cnt;
    base_kl   = kl_cnt;
    cur_op    = op;
    cur_cbc   = cbc && (op == 2'd0 || op == 2'd1);
    axis_slave_done = 1'b0;
    axis_cmd = {29'd0, cbc, op};
    if (cur_cbc) push_blk(ivv);
    for (int i = 0; i < n; i++) push_blk(pblk[i]);
    axis_slave_done = 1'b1;
    exp_n = 0;
    if (cur_cbc) m_iv = ivv;
    if (op == 2'd2) begin
      m_key = pblk[0];
    end else if (op != 2'd3) begin
      for (int i = 0; i < n; i++) begin
        if (op == 2'd0) begin
          c = cur_cbc ? core_enc(m_key, pblk[i] ^ m_iv) : core_enc(m_key, pblk[i]);
          if (cur_cbc) m_iv = c;
        end else begin
          c = cur_cbc ? (core_dec(m_key, pblk[i]) ^ m_iv) : core_dec(m_key, pblk[i]);
          if (cur_cbc) m_iv = pblk[i];
        end
        expq[exp_n] = c;
        exp_n++;
      end
    end
  endtask

  task automatic wait_packet(input string tag);
    int t = 0;
    while (done_cnt == base_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, 512'(done_cnt != base_done), 512'(1));
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 512'(done_cnt - base_done), 512'(1));
    chk({tag, "_wr_count"}, 512'(out_cnt - base_wr), 512'(exp_n));
    for (int i = 0; i < exp_n; i++)
      chk({tag, "_wdata"}, 512'(outd[8'(base_wr + i)]), 512'(expq[i]));
    if (cur_cbc) chk({tag, "_iv_reg"}, 512'(dut.iv_q), 512'(m_iv));
    if (cur_op == 2'd2) begin
      chk({tag, "_key_load_once"}, 512'(kl_cnt - base_kl), 512'(1));
      chk({tag, "_key_value"}, 512'(aes_key), 512'(m_key));
    end
    chk({tag, "_idle"}, 512'(sched_busy), 512'(0));
  endtask

  initial begin
    logic [127:0] c0, c1;
    int t;
    int p0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    axis_cmd        = '0;
    axis_slave_done = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ctrl", 512'({in_fifo_r_e, aes_key_load, aes_decrypt, aes_start,
                          out_fifo_wvalid, sched_busy, sched_done}), 512'(0));
    chk("rst_key", 512'(aes_key), 512'(0));
    chk("rst_blk_in", 512'(aes_blk_in), 512'(0));
    chk("rst_wdata", 512'(out_fifo_wdata), 512'(0));
    chk("rst_iv", 512'(dut.iv_q), 512'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Set-key packet with one trailing block that must be discarded.
    pblk[0] = FK;
    pblk[1] = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    load_packet(2'd2, 1'b0, 2, '0);
    wait_packet("setkey");

    // ECB encrypt of the FIPS-197 block, with latency checks.
    core_lat = 3;
    pblk[0] = FP;
    load_packet(2'd0, 1'b0, 1, '0);
    wait_packet("ecb_fips");
    chk("ecb_fips_out", 512'(outd[8'(base_wr)]), 512'(FC));
    chk("ecb_latency", 512'(last_wr_cyc - last_pop_cyc), 512'(core_lat + 2));
    chk("done_after_write", 512'(last_done_cyc - last_wr_cyc), 512'(2));

    // CBC encrypt, IV=0, two identical blocks.
    pblk[0] = FP;
    pblk[1] = FP;
    load_packet(2'd0, 1'b1, 2, '0);
    wait_packet("cbc_enc");
    c0 = outd[8'(base_wr)];
    c1 = outd[8'(base_wr + 1)];
    chk("cbc_enc_differ", 512'(c0 != c1), 512'(1));
    chk("cbc_enc_chain", 512'(c1), 512'(core_enc(FK, FP ^ c0)));

    // CBC decrypt of those ciphertexts back to the plaintext.
    pblk[0] = c0;
    pblk[1] = c1;
    load_packet(2'd1, 1'b1, 2, '0);
    wait_packet("cbc_dec");
    chk("cbc_dec_p0", 512'(outd[8'(base_wr)]), 512'(FP));
    chk("cbc_dec_p1", 512'(outd[8'(base_wr + 1)]), 512'(FP));
    chk("cbc_dec_iv", 512'(dut.iv_q), 512'(c1));

    // Output FIFO blocked for 10 cycles during PUSH.
    wr_mode = 2;
    pblk[0] = {$urandom, $urandom, $urandom, $urandom};
    pblk[1] = {$urandom, $urandom, $urandom, $urandom};
    load_packet(2'd0, 1'b0, 2, '0);
    t = 0;
    while (!out_fifo_wvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_wvalid_seen", 512'(out_fifo_wvalid), 512'(1));
    p0 = pop_cnt;
    repeat (10) @(negedge clk);
    chk("stall_no_pop", 512'(pop_cnt), 512'(p0));
    chk("stall_no_write", 512'(out_cnt - base_wr), 512'(0));
    wr_mode = 0;
    wait_packet("stall");

    // Reset during WAIT aborts the packet.
    core_lat = 20;
    pblk[0] = {$urandom, $urandom, $urandom, $urandom};
    load_packet(2'd0, 1'b0, 1, '0);
    t = 0;
    while (!aes_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("abort_start_seen", 512'(aes_start), 512'(1));
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_ctrl", 512'({in_fifo_r_e, aes_key_load, aes_decrypt, aes_start,
                            out_fifo_wvalid, sched_busy, sched_done}), 512'(0));
    chk("abort_key", 512'(aes_key), 512'(0));
    chk("abort_blk_in", 512'(aes_blk_in), 512'(0));
    chk("abort_wdata", 512'(out_fifo_wdata), 512'(0));
    @(negedge clk);
    resetn = 1'b1;
    m_key = '0;
    m_iv  = '0;
    repeat (2) @(negedge clk);
    core_lat = 2;
    pblk[0] = {$urandom, $urandom, $urandom, $urandom};
    load_packet(2'd0, 1'b0, 1, '0);
    wait_packet("post_reset_ecb");

    // Randomised packets with FIFO gaps and output back-pressure.
    gap_en  = 1'b1;
    wr_mode = 1;
    for (int p = 0; p < 14; p++) begin
      logic [1:0]   op;
      bit           cbc;
      int           n;
      logic [127:0] ivv;
      op       = 2'($urandom_range(0, 3));
      cbc      = 1'($urandom_range(0, 1));
      n        = $urandom_range(1, 4);
      core_lat = $urandom_range(1, 5);
      key_lat  = $urandom_range(1, 4);
      ivv      = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < n; i++) pblk[i] = {$urandom, $urandom, $urandom, $urandom};
      load_packet(op, cbc, n, ivv);
      wait_packet("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
